// File: rtl/adder_share_arbiter_if.sv
// Request, shared-adder and response signals of adder_share_arbiter.
// The arbiter connects through the slave modport; its environment uses master.
interface adder_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_a0;
    logic [NUM_REQ*DATA_W-1:0] req_a1;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         add_a0;
    logic [DATA_W-1:0]         add_a1;
    logic [DATA_W-1:0]         add_y;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_y;

    modport master (
        output req_valid, req_a0, req_a1, add_y, rsp_ready,
        input  req_ready, add_a0, add_a1, rsp_valid, rsp_id, rsp_y
    );

    modport slave (
        input  req_valid, req_a0, req_a1, add_y, rsp_ready,
        output req_ready, add_a0, add_a1, rsp_valid, rsp_id, rsp_y
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one pipelined adder, with a credit-protected response FIFO.
// Define ADDER_SHARE_ARB_STATS_EN to add the saturating issue/stall counters.
module adder_share_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 16,
    parameter int PIPE_LAT   = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    adder_share_arbiter_if.slave  bus
`ifdef ADDER_SHARE_ARB_STATS_EN
    ,
    output logic [31:0]           stat_issue_cnt,
    output logic [31:0]           stat_stall_cnt
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] y;
    } rsp_t;

    logic [DATA_W-1:0] op_a0 [NUM_REQ];
    logic [DATA_W-1:0] op_a1 [NUM_REQ];
    logic [ID_W-1:0]   prio_ptr;
    logic [ID_W-1:0]   ptr_next;
    logic [ID_W-1:0]   cand;
    logic              grant_vld;
    logic [ID_W-1:0]   grant_id;
    logic              has_credit;

    logic [PIPE_LAT-1:0] pipe_vld;
    logic [ID_W-1:0]     pipe_id [PIPE_LAT];
    logic [CNT_W-1:0]    inflight_count;

    rsp_t              fifo_mem [FIFO_DEPTH];
    rsp_t              head_hold;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_nonempty;
    logic              push;
    logic              pop;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_a0[g] = bus.req_a0[g*DATA_W +: DATA_W];
        assign op_a1[g] = bus.req_a1[g*DATA_W +: DATA_W];
    end

    // Every issued operation owns a slot, either still in the adder or already queued.
    always_comb inflight_count = CNT_W'($countones(pipe_vld));
    assign has_credit = (int'(fifo_count) + int'(inflight_count)) < FIFO_DEPTH;

    always_comb begin
        // NOTE: every output of this block gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = '0;
        if (rst_n && has_credit) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = ID_W'((int'(prio_ptr) + k) % NUM_REQ);
                if (!grant_vld && bus.req_valid[cand]) begin
                    grant_vld = 1'b1;
                    grant_id  = cand;
                end
            end
        end
    end

    assign ptr_next      = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign bus.req_ready = grant_vld ? (NUM_REQ'(1) << grant_id) : '0;
    assign bus.add_a0    = grant_vld ? op_a0[grant_id] : '0;
    assign bus.add_a1    = grant_vld ? op_a1[grant_id] : '0;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            prio_ptr <= '0;
            pipe_vld <= '0;
            for (int s = 0; s < PIPE_LAT; s++) pipe_id[s] <= '0;
        end else begin
            if (grant_vld) prio_ptr <= ptr_next;
            pipe_vld[0] <= grant_vld;
            pipe_id[0]  <= grant_id;
            for (int s = 1; s < PIPE_LAT; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_id[s]  <= pipe_id[s-1];
            end
        end
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_nonempty = (fifo_count != '0);
    assign push          = pipe_vld[PIPE_LAT-1];
    assign pop           = fifo_nonempty && bus.rsp_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            head_hold  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (fifo_nonempty) head_hold <= fifo_mem[rd_ptr];
        end
    end

    // NOTE: the storage array has no reset; fifo_count alone decides which
    // entries are meaningful, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{id: pipe_id[PIPE_LAT-1], y: bus.add_y};
    end

    assign bus.rsp_valid = fifo_nonempty;
    assign bus.rsp_id    = fifo_nonempty ? fifo_mem[rd_ptr].id : head_hold.id;
    assign bus.rsp_y     = fifo_nonempty ? fifo_mem[rd_ptr].y  : head_hold.y;

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (int'(fifo_count) == FIFO_DEPTH)));

`ifdef ADDER_SHARE_ARB_STATS_EN
    logic any_valid;
    assign any_valid = |bus.req_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_issue_cnt <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (grant_vld && (stat_issue_cnt != '1))
                stat_issue_cnt <= stat_issue_cnt + 1'b1;
            if (any_valid && !has_credit && (stat_stall_cnt != '1))
                stat_stall_cnt <= stat_stall_cnt + 1'b1;
        end
    end
`else
    // Statistics counters are compiled out of this build.
`endif
endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one 16-bit registered adder (2-stage pipeline: input regs, then output reg) between NUM_REQ requesters.
- Round-robin arbitration with valid/ready request handshake.
- Tracks in-flight operations and returns each result with the requester ID through a credit-protected response FIFO.
- The adder cannot stall, so the block never issues an operation without a guaranteed FIFO slot.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 16, operand/result width; must match adder BIT_WIDTH
- PIPE_LAT, 2, cycles from operands driven on add_a0/add_a1 to result valid on add_y
- FIFO_DEPTH, 4, response FIFO entries; must be >= PIPE_LAT+1 for full throughput
- ID_W, 2, requester ID width, = clog2(NUM_REQ)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low; same reset also drives the shared adder
- req_valid  in  NUM_REQ  per-requester request valid
- req_a0  in  NUM_REQ*DATA_W  packed operand A0; requester i at bits [i*DATA_W +: DATA_W]
- req_a1  in  NUM_REQ*DATA_W  packed operand A1, same packing
- req_ready  out  NUM_REQ  one-hot grant; request i accepted when req_valid[i] && req_ready[i]
- add_a0  out  DATA_W  operand to adder A0
- add_a1  out  DATA_W  operand to adder A1
- add_y  in  DATA_W  adder result Y
- rsp_valid  out  1  response FIFO non-empty
- rsp_ready  in  1  consumer accepts head response
- rsp_id  out  ID_W  requester ID of head response
- rsp_y  out  DATA_W  sum of head response

Behaviour:
- Reset (rst_n=0 at posedge):
  - Priority pointer = 0.
  - In-flight shift register cleared.
  - FIFO emptied, so rsp_valid=0; rsp_id/rsp_y = 0.
  - req_ready = 0; add_a0/add_a1 = 0.
- Reset mid-operation: in-flight operations are discarded and no response is produced for them.
- Credit: credit = FIFO_DEPTH - fifo_count - inflight_count, using registered values. A pop in the current cycle does not add credit until the next cycle.
- Arbitration (combinational, each cycle):
  - If credit > 0 and any req_valid is set, grant the first set req_valid[i] scanning from the pointer upward, wrapping modulo NUM_REQ.
  - req_ready = one-hot of the grant; all zero when credit == 0.
- Pointer: after a grant to i, pointer <= (i+1) mod NUM_REQ. With no grant, the pointer holds.
- Operand mux:
  - add_a0/add_a1 = operands of the granted requester; 0 when there is no grant.
  - req_ready is not a function of rsp_ready.
- In-flight tracking:
  - PIPE_LAT-deep shift register of {valid, id}.
  - Stage 0 is loaded with {grant, granted id} each cycle.
  - When the last stage is valid, add_y is sampled and {id, add_y} is pushed into the FIFO in that same cycle.
- Latency:
  - Issue at cycle t → result pushed at end of cycle t+PIPE_LAT → rsp_valid high in cycle t+PIPE_LAT+1 at the earliest.
  - Throughput is one operation per cycle when FIFO_DEPTH >= PIPE_LAT+1 and rsp_ready is held at 1.
- FIFO:
  - Circular buffer with wrap-around read/write pointers.
  - A simultaneous push and pop keeps the count unchanged.
  - Overflow is impossible by credit; a push when full is a design error (assertion).
  - rsp_id/rsp_y show the head entry when non-empty and hold their last value when empty.
- Arithmetic: sum is modulo 2^DATA_W, carry discarded (inherited from the adder).
- Requester obligations: hold req_valid and operands stable until accepted. Dropping req_valid before acceptance is allowed, and no operation is issued.

Optional Feature:
- Macro: ADDER_SHARE_ARB_STATS_EN.
- Defined:
  - Adds output port stat_issue_cnt (32 bits), incremented on every grant and saturating at 0xFFFFFFFF.
  - Adds output port stat_stall_cnt (32 bits), incremented each cycle with any req_valid set while credit == 0, also saturating.
  - Both counters clear on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Single request: req 1, a0=0x0003, a1=0x0004, rsp_ready=1 → req_ready[1] in the same cycle; rsp_valid 3 cycles later with rsp_id=1, rsp_y=0x0007.
- All four requesters valid continuously, rsp_ready=1 → grants in order 0,1,2,3,0…, one per cycle; responses in issue order with correct sums.
- Wrap: a0=0xFFFF, a1=0x0002 → rsp_y=0x0001.
- rsp_ready=0 with continuous requests → exactly FIFO_DEPTH grants, then req_ready=0; after rsp_ready=1, one pop per cycle, issue resumes the cycle after the first pop, and no response is lost or duplicated.
- Reset asserted one cycle after issuing two operations → no rsp_valid afterwards; pointer returns to 0, so requester 0 wins the first contested grant.
- With ADDER_SHARE_ARB_STATS_EN: 10 grants and 5 stalled cycles → stat_issue_cnt=10, stat_stall_cnt=5; both read 0 after reset.
